panel_input: RTL and testbench
==============================

# panel_input

Front-panel input stage of the washing-machine controller, feeding `connect` directly. It synchronises and debounces the raw door switch and start button, and validates and latches the load selection. It presents `connect` with a clean `door` level, a held `start` request and a stable `load` code. It watches a `busy` summary of the washer outputs so the request is withdrawn once the cycle is running and the load code is frozen for the whole cycle.

## Interface
- `DB_CYCLES`, 4 — consecutive stable cycles (after sync) needed to accept a new debounced level; legal 1..255.
- `ARM_TIMEOUT`, 16 — cycles `start` stays asserted without `busy` before the request is abandoned; legal 1..65535.
- `clk` in 1 — single clock; all logic rising-edge.
- `reset` in 1 — asynchronous, active-high.
- `door_raw` in 1 — raw door switch, 1 = open.
- `start_btn` in 1 — raw start button, 1 = pressed.
- `load_sel` in 2 — raw load selector; 0 = none, 1..3 = small/medium/large.
- `busy` in 1 — OR of `agitator|motor|pump|water` from `connect`.
- `door` out 1 — debounced door level to `connect`.
- `start` out 1 — start request to `connect`.
- `load` out 2 — latched load code to `connect`.
- `err` out 1 — one-cycle pulse on a rejected or timed-out request.

## Operation
- `door_raw` and `start_btn` each pass through a 2-flop synchroniser, then a debouncer.
  - Each debouncer has an 8-bit counter. It clears when the synced input equals the current debounced level, and otherwise increments.
  - When the counter reaches `DB_CYCLES`, the debounced level toggles and the counter clears.
- `load_sel` is sampled only at the press instant and is not debounced.
- A press is a rising edge of the debounced start (`db_start` & ~`db_start_q`).
- The state machine has three states, encoded 2 bits: IDLE, ARMED, RUN.
  - IDLE: `start`=0. On a press:
    - If `door`=0 and `load_sel`≠0: latch `load`←`load_sel`, clear the timer, go to ARMED.
    - Otherwise: pulse `err` for one cycle, stay IDLE, leave `load` unchanged.
  - ARMED: `start`=1, and the timer increments every cycle.
    - `busy`=1 → RUN.
    - Else `door`=1 → IDLE with no `err`.
    - Else timer = `ARM_TIMEOUT`−1 → IDLE and pulse `err`.
    - Priority is busy > door > timeout.
  - RUN: `start`=0, `load` held. When `busy`=0, go to IDLE.
    - Door opening in RUN is passed through on `door` only; handling it is `connect`'s job.
- Presses in ARMED or RUN are ignored. They produce no `err`, and `load` does not change.
- `load` keeps the last latched value after the cycle ends, until the next accepted press.
- The timer is 16-bit and saturates; it cannot wrap.

## Timing
- Reset values: `door`=0, `start`=0, `load`=0, `err`=0, state IDLE, synchronisers, debounced levels and counters 0.
- Reset mid-cycle (ARMED/RUN) drops `start` and zeroes `load` immediately and asynchronously.
- Raw input to debounced level: 2 sync cycles + `DB_CYCLES` cycles. With the default that is 6 cycles.
- Debounced press to `start`=1 and `load` valid: 1 cycle, both in the same cycle, so `load` is never seen changing under `start`.
- `busy` rising to `start`=0: 1 cycle. In ARMED, `start` stays high for the first cycle in which `busy`=1.
- `err` is high for exactly one cycle, registered on the cycle after the decision.
- A glitch shorter than `DB_CYCLES` synced cycles never reaches `door` or `start`.

## Configuration
- `PANEL_DOOR_LOCK_EN` defined:
  - Adds output `door_lock` (1 bit), registered and high in ARMED and RUN, 0 at reset.
  - While `door_lock`=1, the door debouncer holds its level and counter, so `door` cannot rise. The ARMED door-abort therefore never fires.
- Undefined: no `door_lock` port, and door handling is as described under Operation.

## Test plan
- Reset: assert `reset` mid-ARMED with `load`=2 → `start`=0 and `load`=0 in the same cycle.
- Glitch: `start_btn` high for 3 cycles with `DB_CYCLES`=4 → no `start` and no `err`.
- Normal run: door closed, `load_sel`=3, hold the press for 10 cycles → `start`=1 and `load`=3 at cycle 7; drive `busy`=1 at cycle 12 → `start`=0 at cycle 13; drop `busy` → IDLE, `load` stays 3.
- Rejects:
  - Press with `load_sel`=0 → `err` one-cycle pulse, `start` stays 0.
  - Press with `door_raw`=1, debounced → `err` pulse, `start` stays 0.
- Timeout/abort:
  - `ARM_TIMEOUT`=16 with `busy` never high → `start` high for exactly 16 cycles, then `err` pulse.
  - Repeat with the door opened during ARMED → `start` falls after the debounce delay and no `err`.
- Lock (`PANEL_DOOR_LOCK_EN`): open the door during RUN → `door` stays 0 and `door_lock`=1 until `busy` falls.

Source files
------------

// File: rtl/panel_input.sv
// Front-panel input stage: synchronises and debounces door/start, validates and latches load.
// Optional PANEL_DOOR_LOCK_EN adds a door_lock output that freezes the door debouncer while a cycle is armed or running.

module panel_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  input  logic hold_i,
  output logic level_o
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] DbLimit = CntW'(DB_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            level_q, level_d;

  assign cnt_inc = CntW'(cnt_q + CntW'(1));

  // Count consecutive disagreeing samples; toggle once the run reaches the limit.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!hold_i) begin
      if (sync_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_inc == DbLimit) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

module panel_input #(
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned ARM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_raw,
  input  logic       start_btn,
  input  logic [1:0] load_sel,
  input  logic       busy,
  output logic       door,
  output logic       start,
  output logic [1:0] load,
  output logic       err
`ifdef PANEL_DOOR_LOCK_EN
  ,
  output logic       door_lock
`endif
);

  localparam int unsigned TimerW = 16;
  localparam int unsigned LoadW  = 2;
  localparam logic [TimerW-1:0] TmoLast = TimerW'(ARM_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TmoMax  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        door_sync_q, start_sync_q;
  logic              db_door, db_start, db_start_q;
  logic              door_hold, press;
  logic              accept, reject, timeout;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              start_q, start_d;
  logic [LoadW-1:0]  load_q, load_d;
  logic              err_q, err_d;
  logic              door_lock_q, door_lock_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      door_sync_q  <= '0;
      start_sync_q <= '0;
    end else begin
      door_sync_q  <= {door_sync_q[0], door_raw};
      start_sync_q <= {start_sync_q[0], start_btn};
    end
  end

`ifdef PANEL_DOOR_LOCK_EN
  assign door_hold = door_lock_q;
`else
  assign door_hold = 1'b0;
`endif

  panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_door (
    .clk     (clk),
    .reset   (reset),
    .sync_i  (door_sync_q[1]),
    .hold_i  (door_hold),
    .level_o (db_door)
  );

  panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk     (clk),
    .reset   (reset),
    .sync_i  (start_sync_q[1]),
    .hold_i  (1'b0),
    .level_o (db_start)
  );

  assign press = db_start & ~db_start_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; in ARMED the priority is busy, then door abort, then timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          if (!db_door && (load_sel != '0)) begin
            state_d = ST_ARMED;
            accept  = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (busy) begin
          state_d = ST_RUN;
        end else if (db_door) begin
          state_d = ST_IDLE;
        end else if (timer_q == TmoLast) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end
      end
      ST_RUN: begin
        if (!busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so start and load move on the same edge.
  always_comb begin
    start_d     = (state_d == ST_ARMED);
    load_d      = accept ? load_sel : load_q;
    err_d       = reject | timeout;
    door_lock_d = (state_d != ST_IDLE);
    timer_d     = timer_q;
    if (accept) begin
      timer_d = '0;
    end else if ((state_q == ST_ARMED) && (timer_q != TmoMax)) begin
      timer_d = TimerW'(timer_q + TimerW'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_start_q  <= 1'b0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      load_q      <= '0;
      err_q       <= 1'b0;
      door_lock_q <= 1'b0;
    end else begin
      db_start_q  <= db_start;
      timer_q     <= timer_d;
      start_q     <= start_d;
      load_q      <= load_d;
      err_q       <= err_d;
      door_lock_q <= door_lock_d;
    end
  end

  assign door  = db_door;
  assign start = start_q;
  assign load  = load_q;
  assign err   = err_q;
`ifdef PANEL_DOOR_LOCK_EN
  assign door_lock = door_lock_q;
`endif

endmodule

// File: tb/tb_panel_input.sv
// Scoreboard bench for panel_input: every change of {door,start,load,err} is matched, with its
// cycle stamp, against an expected-event queue; spot checks at fixed cycles come from a second queue.

module tb_panel_input;

  typedef struct {
    int         cyc;
    logic [4:0] v;
    bit         use_lk;
    logic       lk;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       door_raw;
  logic       start_btn;
  logic [1:0] load_sel;
  logic       busy;
  logic       door;
  logic       start;
  logic [1:0] load;
  logic       err;
  logic       lock_w;

  int   cyc;
  int   checks;
  int   fails;
  int   n0;
  bit   drain_req;
  bit   drain_done;
  exp_t ev_q[$];
  exp_t ck_q[$];
  logic [4:0] mon_v;
  logic [4:0] mon_prev;
  exp_t mon_e;

  panel_input #(.DB_CYCLES(4), .ARM_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .door_raw  (door_raw),
    .start_btn (start_btn),
    .load_sel  (load_sel),
    .busy      (busy),
    .door      (door),
    .start     (start),
    .load      (load),
    .err       (err)
`ifdef PANEL_DOOR_LOCK_EN
    ,
    .door_lock (lock_w)
`endif
  );

`ifndef PANEL_DOOR_LOCK_EN
  assign lock_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares on every output change and at every scheduled spot check.
  initial begin
    checks = 0;
    fails = 0;
    mon_prev = 5'b00000;
    drain_done = 1'b0;
  end

  always @(negedge clk) begin
    mon_v = {door, start, load, err};
    if (ck_q.size() > 0 && ck_q[0].cyc == cyc) begin
      mon_e = ck_q.pop_front();
      checks++;
      if (mon_v !== mon_e.v || (mon_e.use_lk && lock_w !== mon_e.lk)) begin
        fails++;
        $display("FAIL spot cyc=%0d got=%b lock=%b want=%b lock=%b", cyc, mon_v, lock_w, mon_e.v, mon_e.lk);
      end
    end
    if (mon_v !== mon_prev) begin
      checks++;
      if (ev_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d got=%b prev=%b", cyc, mon_v, mon_prev);
      end else begin
        mon_e = ev_q.pop_front();
        if (mon_v !== mon_e.v || cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL event got=%b at cyc %0d want=%b at cyc %0d", mon_v, cyc, mon_e.v, mon_e.cyc);
        end
      end
      mon_prev = mon_v;
    end
    if (drain_req && !drain_done) begin
      checks++;
      if (ev_q.size() != 0 || ck_q.size() != 0) begin
        fails++;
        $display("FAIL drain pending_events=%0d pending_spots=%0d want 0", ev_q.size(), ck_q.size());
      end
      drain_done = 1'b1;
    end
  end

  function automatic void ev(int c, logic [4:0] v);
    exp_t e;
    e.cyc = c; e.v = v; e.use_lk = 1'b0; e.lk = 1'b0;
    ev_q.push_back(e);
  endfunction

  function automatic void ck(int c, logic [4:0] v, bit use_lk, logic lk);
    exp_t e;
    e.cyc = c; e.v = v; e.use_lk = use_lk; e.lk = lk;
    ck_q.push_back(e);
  endfunction

  task automatic wait_to(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected vectors are {door, start, load[1:0], err}.
  initial begin
    drain_req = 1'b0;
    reset = 1'b1;
    door_raw = 1'b0;
    start_btn = 1'b0;
    load_sel = 2'd0;
    busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ck(cyc + 1, 5'b00000, 1'b1, 1'b0);
    wait_to(cyc + 2);

    // Glitch of 3 cycles never debounces.
    n0 = cyc;
    start_btn = 1'b1;
    ck(n0 + 10, 5'b00000, 1'b0, 1'b0);
    wait_to(n0 + 3);
    start_btn = 1'b0;
    wait_to(n0 + 12);

    // Normal run, load 3, busy at +12.
    n0 = cyc;
    start_btn = 1'b1;
    load_sel = 2'd3;
    ev(n0 + 7, 5'b01110);
    ev(n0 + 13, 5'b00110);
    ck(n0 + 20, 5'b00110, 1'b1, 1'b0);
    wait_to(n0 + 10);
    start_btn = 1'b0;
    wait_to(n0 + 12);
    busy = 1'b1;
    wait_to(n0 + 16);
    busy = 1'b0;
    load_sel = 2'd0;
    wait_to(n0 + 24);

    // Reject: load_sel 0.
    n0 = cyc;
    start_btn = 1'b1;
    ev(n0 + 7, 5'b00111);
    ev(n0 + 8, 5'b00110);
    wait_to(n0 + 8);
    start_btn = 1'b0;
    wait_to(n0 + 16);

    // Reject: door open.
    n0 = cyc;
    door_raw = 1'b1;
    ev(n0 + 6, 5'b10110);
    ev(n0 + 15, 5'b10111);
    ev(n0 + 16, 5'b10110);
    ev(n0 + 22, 5'b00110);
    wait_to(n0 + 8);
    start_btn = 1'b1;
    load_sel = 2'd2;
    wait_to(n0 + 16);
    start_btn = 1'b0;
    door_raw = 1'b0;
    load_sel = 2'd0;
    wait_to(n0 + 26);

    // Timeout: start high exactly 16 cycles, then err.
    n0 = cyc;
    start_btn = 1'b1;
    load_sel = 2'd1;
    ev(n0 + 7, 5'b01010);
    ev(n0 + 23, 5'b00011);
    ev(n0 + 24, 5'b00010);
    wait_to(n0 + 10);
    start_btn = 1'b0;
    load_sel = 2'd0;
    wait_to(n0 + 28);

    // Door opened while ARMED.
    n0 = cyc;
    start_btn = 1'b1;
    load_sel = 2'd2;
    ev(n0 + 7, 5'b01100);
`ifdef PANEL_DOOR_LOCK_EN
    ev(n0 + 23, 5'b00101);
    ev(n0 + 24, 5'b00100);
`else
    ev(n0 + 15, 5'b11100);
    ev(n0 + 16, 5'b10100);
    ev(n0 + 24, 5'b00100);
`endif
    wait_to(n0 + 9);
    door_raw = 1'b1;
    wait_to(n0 + 10);
    start_btn = 1'b0;
    load_sel = 2'd0;
    wait_to(n0 + 18);
    door_raw = 1'b0;
    wait_to(n0 + 28);

`ifdef PANEL_DOOR_LOCK_EN
    // Door opened during RUN is held off until busy falls.
    n0 = cyc;
    start_btn = 1'b1;
    load_sel = 2'd1;
    ev(n0 + 7, 5'b01010);
    ev(n0 + 10, 5'b00010);
    ck(n0 + 20, 5'b00010, 1'b1, 1'b1);
    ck(n0 + 24, 5'b00010, 1'b1, 1'b0);
    ev(n0 + 27, 5'b10010);
    ev(n0 + 34, 5'b00010);
    wait_to(n0 + 9);
    busy = 1'b1;
    wait_to(n0 + 10);
    start_btn = 1'b0;
    load_sel = 2'd0;
    wait_to(n0 + 11);
    door_raw = 1'b1;
    wait_to(n0 + 22);
    busy = 1'b0;
    wait_to(n0 + 28);
    door_raw = 1'b0;
    wait_to(n0 + 36);
`endif

    // Asynchronous reset mid-ARMED with load 2.
    n0 = cyc;
    start_btn = 1'b1;
    load_sel = 2'd2;
    ev(n0 + 7, 5'b01100);
    ev(n0 + 9, 5'b00000);
    ck(n0 + 14, 5'b00000, 1'b1, 1'b0);
    wait_to(n0 + 9);
    reset = 1'b1;
    wait_to(n0 + 10);
    start_btn = 1'b0;
    load_sel = 2'd0;
    wait_to(n0 + 11);
    reset = 1'b0;
    wait_to(n0 + 16);

    drain_req = 1'b1;
    for (int i = 0; i < 50 && !drain_done; i++) @(posedge clk);
    if (!drain_done) begin
      $display("FAIL drain_timeout got=0 want=1");
      $fatal(1, "monitor did not drain");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
